jk_moore_bank: RTL and testbench
================================

Name: jk_moore_bank

Overview:
- Parametrised bank of CH independent two-state (OFF/ON) Moore FSMs driven by per-channel j/k request pairs.
- Generalises the single-channel JK Moore cell with four things the cell lacks:
  - a selectable both-asserted (j&k) policy
  - a programmable minimum-dwell lockout after every transition
  - a global enable
  - one-cycle rise/fall event pulses
- Used wherever a group of latched on/off status bits (enables, mode flags) is set and cleared by request strobes.

Parameters:
- CH, 4, number of independent channels (1..32).
- DWELL_W, 4, width of the dwell lockout counter and the dwell input.
- CNT_W, 16, width of the optional transition counter.

Ports:
- clk  input  1  rising-edge clock.
- areset_n  input  1  asynchronous active-low reset.
- en  input  1  global enable; when 0, all state, counters and pulses freeze or clear (see Behaviour).
- j  input  CH  per-channel set request (level).
- k  input  CH  per-channel clear request (level).
- jk_mode  input  2  policy when j[i]&k[i]: 00 toggle, 01 hold, 10 set-priority, 11 clear-priority.
- dwell  input  DWELL_W  lockout length in cycles, loaded on each transition; 0 means no lockout.
- out  output  CH  Moore output, 1 when the channel is ON.
- busy  output  CH  1 while the channel's dwell counter is nonzero.
- rise  output  CH  one-cycle pulse, first cycle a channel is ON.
- fall  output  CH  one-cycle pulse, first cycle a channel is OFF.

Behaviour:
- Reset, asynchronous on areset_n low:
  - all channels go to state OFF, with dwell counters 0.
  - out, busy, rise, fall = 0; trans_cnt = 0 when compiled in.
  - Release is synchronous to clk; the first edge with areset_n high evaluates normally.
- Per-channel state: OFF (out=0) and ON (out=1). out is a direct decode of the state register, with no combinational path from j/k.
- Transition request req[i], evaluated each clk edge when en=1:
  - OFF: j&~k -> ON. ~j&k or ~j&~k -> stay.
  - ON: k&~j -> OFF. j&~k or ~j&~k -> stay.
  - j&k with jk_mode 00: go to the opposite state.
  - j&k with jk_mode 01: stay.
  - j&k with jk_mode 10: go to ON.
  - j&k with jk_mode 11: go to OFF.
- Dwell lockout:
  - On any state change, cnt[i] loads the dwell value sampled on that same edge.
  - While cnt[i]!=0 and en=1, cnt[i] decrements by 1 per cycle and all requests are ignored.
  - A request is honoured on the edge where cnt[i]==0, so after a transition with dwell=D the earliest next transition is D+1 edges later.
  - Changing dwell mid-count does not affect the running count.
  - busy[i] = (cnt[i]!=0).
- Events:
  - rise[i]=1 for exactly the one cycle after an OFF->ON edge.
  - fall[i]=1 for exactly the one cycle after an ON->OFF edge.
  - Both are registered, never simultaneous on one channel, and 0 otherwise.
- Enable: en=0 holds state and cnt, and forces rise/fall to 0 on the next edge. Requests presented while en=0 are dropped, not queued.
- Channels are fully independent; simultaneous transitions on all channels are legal.
- Reset mid-lockout clears cnt immediately; the channel is free on the first post-reset edge.

Optional Feature:
- Macro JKB_TRANS_CNT_EN.
- Defined:
  - adds output port trans_cnt [CNT_W-1:0].
  - On each enabled edge it adds the number of channels transitioning on that edge (popcount of rise|fall in the next cycle, computed from the same edge).
  - Saturates at all-ones; reset value 0.
- Undefined: the port and all counter logic are absent; the rest of the behaviour is identical.

Decomposition:
- Package jk_bank_pkg holds:
  - state encoding constants ST_OFF=1'b0, ST_ON=1'b1
  - jk_mode constants MODE_TOGGLE=2'b00, MODE_HOLD=2'b01, MODE_SET=2'b10, MODE_CLR=2'b11
- One sub-module, jk_moore_chan: a single channel holding state, dwell counter and rise/fall regs.
- The top instantiates CH copies via generate and holds the optional popcount/saturating trans_cnt.

Test Plan:
- Reset and basic JK: assert areset_n=0 with j=4'hF; after release, out=0, busy=0. Then CH=4, dwell=0, j=4'b0001 for 1 cycle -> out=4'b0001 next cycle, rise=4'b0001 for one cycle; k=4'b0001 -> out=0, fall=4'b0001.
- Both-asserted modes: ch0 ON, j=k=1 on ch0, dwell=0:
  - mode 00 -> toggles every cycle (1,0,1,...)
  - mode 01 -> stays 1
  - mode 10 -> stays 1
  - mode 11 -> goes 0 and stays 0.
- Dwell lockout: dwell=3, j=1 held then k=1 held from the cycle after turn-on:
  - busy high 3 cycles
  - out falls exactly 4 edges after rising
  - dwell changed to 0 mid-lockout has no effect.
- Enable freeze: during lockout (cnt=2) drive en=0 for 5 cycles with k=1 -> out and busy unchanged, no fall pulse. After en=1, lockout completes and the k=1 still held then is honoured.
- Async reset mid-operation: areset_n low between clk edges while out=4'hF and busy set -> out, busy, rise, fall go 0 immediately, with no clk edge required.
- JKB_TRANS_CNT_EN, CNT_W=4:
  - all 4 channels toggle together with mode 00 -> trans_cnt increments by 4 per cycle: 4, 8, 12, 15, 15 (saturates).

Source files
------------

// File: rtl/jk_moore_bank_pkg.sv
// jk_bank_pkg: shared encodings for the JK Moore bank.
//   jk_state_e  : per-channel state (ST_OFF / ST_ON), out is a direct decode
//   MODE_*      : policy applied when j and k are both asserted
package jk_bank_pkg;

    typedef enum logic {
        ST_OFF = 1'b0,
        ST_ON  = 1'b1
    } jk_state_e;

    localparam logic [1:0] MODE_TOGGLE = 2'b00;
    localparam logic [1:0] MODE_HOLD   = 2'b01;
    localparam logic [1:0] MODE_SET    = 2'b10;
    localparam logic [1:0] MODE_CLR    = 2'b11;

endpackage

// File: rtl/jk_moore_bank_if.sv
// jk_moore_bank_if: request/status bundle of the JK Moore bank.
//   en, j, k, jk_mode, dwell : requests and policy (driven by master)
//   out, busy, rise, fall    : per-channel status (driven by slave)
//   trans_cnt                : transition counter, only with JKB_TRANS_CNT_EN
// Modports: master (request side), slave (the bank).
interface jk_moore_bank_if #(
    parameter int CH      = 4,
    parameter int DWELL_W = 4,
    parameter int CNT_W   = 16
);
    logic               en;
    logic [CH-1:0]      j;
    logic [CH-1:0]      k;
    logic [1:0]         jk_mode;
    logic [DWELL_W-1:0] dwell;
    logic [CH-1:0]      out;
    logic [CH-1:0]      busy;
    logic [CH-1:0]      rise;
    logic [CH-1:0]      fall;
`ifdef JKB_TRANS_CNT_EN
    logic [CNT_W-1:0]   trans_cnt;
`endif

    modport master (
        output en, j, k, jk_mode, dwell,
`ifdef JKB_TRANS_CNT_EN
        input  trans_cnt,
`endif
        input  out, busy, rise, fall
    );

    modport slave (
        input  en, j, k, jk_mode, dwell,
`ifdef JKB_TRANS_CNT_EN
        output trans_cnt,
`endif
        output out, busy, rise, fall
    );
endinterface

// File: rtl/jk_moore_bank_chan.sv
// jk_moore_chan: one OFF/ON Moore channel with dwell lockout and event pulses.
//   clk, areset_n : clock, asynchronous active-low reset
//   en            : enable; 0 holds state/counter and clears pulses
//   j, k, jk_mode : set/clear requests and both-asserted policy
//   dwell         : lockout length loaded on each transition
//   out, busy     : state decode, lockout active
//   rise, fall    : one-cycle pulses after a transition
//   step          : (JKB_TRANS_CNT_EN only) transition happens on this edge
module jk_moore_chan
    import jk_bank_pkg::*;
#(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               areset_n,
    input  logic               en,
    input  logic               j,
    input  logic               k,
    input  logic [1:0]         jk_mode,
    input  logic [DWELL_W-1:0] dwell,
`ifdef JKB_TRANS_CNT_EN
    output logic               step,
`endif
    output logic               out,
    output logic               busy,
    output logic               rise,
    output logic               fall
);
    jk_state_e          state_q, state_d, tgt;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               rise_q, rise_d, fall_q, fall_d;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        tgt     = state_q;
        unique case ({j, k})
            2'b10:   tgt = ST_ON;
            2'b01:   tgt = ST_OFF;
            2'b11: begin
                unique case (jk_mode)
                    MODE_TOGGLE: tgt = (state_q == ST_ON) ? ST_OFF : ST_ON;
                    MODE_HOLD:   tgt = state_q;
                    MODE_SET:    tgt = ST_ON;
                    default:     tgt = ST_OFF;
                endcase
            end
            default: tgt = state_q;
        endcase
        // Requests are only looked at once the lockout has run out.
        if (en) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - DWELL_W'(1);
            end else if (tgt != state_q) begin
                state_d = tgt;
                cnt_d   = dwell;
                rise_d  = (tgt == ST_ON);
                fall_d  = (tgt == ST_OFF);
            end
        end
    end

`ifdef JKB_TRANS_CNT_EN
    assign step = (state_d != state_q);
`endif
    assign out  = (state_q == ST_ON);
    assign busy = (cnt_q != '0);
    assign rise = rise_q;
    assign fall = fall_q;
endmodule

// File: rtl/jk_moore_bank.sv
// jk_moore_bank: CH independent JK Moore OFF/ON channels.
//   clk, areset_n : clock, asynchronous active-low reset
//   bus (slave)   : en, j, k, jk_mode, dwell in; out, busy, rise, fall out
// Optional macro JKB_TRANS_CNT_EN adds bus.trans_cnt, a saturating count
// of channel transitions.
module jk_moore_bank
    import jk_bank_pkg::*;
#(
    parameter int CH      = 4,
    parameter int DWELL_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic            clk,
    input  logic            areset_n,
    jk_moore_bank_if.slave  bus
);
    logic [CH-1:0] out_w, busy_w, rise_w, fall_w;
`ifdef JKB_TRANS_CNT_EN
    logic [CH-1:0]    step_w;
    logic [CNT_W-1:0] tcnt_q;
`endif

    for (genvar i = 0; i < CH; i++) begin : g_ch
        jk_moore_chan #(.DWELL_W(DWELL_W)) u_chan (
            .clk      (clk),
            .areset_n (areset_n),
            .en       (bus.en),
            .j        (bus.j[i]),
            .k        (bus.k[i]),
            .jk_mode  (bus.jk_mode),
            .dwell    (bus.dwell),
`ifdef JKB_TRANS_CNT_EN
            .step     (step_w[i]),
`endif
            .out      (out_w[i]),
            .busy     (busy_w[i]),
            .rise     (rise_w[i]),
            .fall     (fall_w[i])
        );
    end

    assign bus.out  = out_w;
    assign bus.busy = busy_w;
    assign bus.rise = rise_w;
    assign bus.fall = fall_w;

`ifdef JKB_TRANS_CNT_EN
    function automatic logic [5:0] popcount(input logic [CH-1:0] v);
        logic [5:0] n;
        n = '0;
        for (int b = 0; b < CH; b++) n = n + 6'(v[b]);
        return n;
    endfunction

    // Extra headroom bits catch any carry out of the counter width.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [5:0] n);
        logic [CNT_W+6:0] s;
        s = (CNT_W+7)'(a) + (CNT_W+7)'(n);
        if (s[CNT_W+6:CNT_W] != '0) return '1;
        return s[CNT_W-1:0];
    endfunction

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n)   tcnt_q <= '0;
        else if (bus.en) tcnt_q <= sat_add(tcnt_q, popcount(step_w));
    end

    assign bus.trans_cnt = tcnt_q;
`endif
endmodule

// File: tb/tb_jk_moore_bank.sv
// tb_jk_moore_bank: scoreboard bench for jk_moore_bank (CH=4, DWELL_W=4,
// CNT_W=4). trans_cnt checks are active when JKB_TRANS_CNT_EN is defined.
module tb_jk_moore_bank;
    localparam int CH      = 4;
    localparam int DWELL_W = 4;
    localparam int CNT_W   = 4;

    typedef struct {
        logic [CH-1:0]    out;
        logic [CH-1:0]    busy;
        logic [CH-1:0]    rise;
        logic [CH-1:0]    fall;
        logic [CNT_W-1:0] tc;
    } exp_t;

    logic clk;
    logic areset_n;
    int   n_cmp;
    int   n_mis;
    exp_t sb[$];

    logic [CH-1:0]    m_out, m_rise, m_fall;
    int               m_cnt[CH];
    int               m_tc;

    jk_moore_bank_if #(.CH(CH), .DWELL_W(DWELL_W), .CNT_W(CNT_W)) bus();

    jk_moore_bank #(.CH(CH), .DWELL_W(DWELL_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .areset_n (areset_n),
        .bus      (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_out  = '0;
        m_rise = '0;
        m_fall = '0;
        m_tc   = 0;
        for (int i = 0; i < CH; i++) m_cnt[i] = 0;
    endtask

    // Reference behaviour for the next clock edge given the current inputs.
    task automatic model_step();
        int   trans;
        logic tgt;
        trans  = 0;
        m_rise = '0;
        m_fall = '0;
        if (bus.en) begin
            for (int i = 0; i < CH; i++) begin
                if (m_cnt[i] != 0) begin
                    m_cnt[i] = m_cnt[i] - 1;
                end else begin
                    tgt = m_out[i];
                    if (bus.j[i] && !bus.k[i]) tgt = 1'b1;
                    else if (!bus.j[i] && bus.k[i]) tgt = 1'b0;
                    else if (bus.j[i] && bus.k[i]) begin
                        case (bus.jk_mode)
                            2'd0: tgt = !m_out[i];
                            2'd1: tgt = m_out[i];
                            2'd2: tgt = 1'b1;
                            default: tgt = 1'b0;
                        endcase
                    end
                    if (tgt != m_out[i]) begin
                        m_out[i]  = tgt;
                        m_cnt[i]  = int'(bus.dwell);
                        m_rise[i] = tgt;
                        m_fall[i] = !tgt;
                        trans++;
                    end
                end
            end
            m_tc = m_tc + trans;
            if (m_tc > (1 << CNT_W) - 1) m_tc = (1 << CNT_W) - 1;
        end
    endtask

    task automatic cycle();
        exp_t e;
        logic [CH-1:0] b;
        model_step();
        for (int i = 0; i < CH; i++) b[i] = (m_cnt[i] != 0);
        e.out  = m_out;
        e.busy = b;
        e.rise = m_rise;
        e.fall = m_fall;
        e.tc   = CNT_W'(m_tc);
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("out",  32'(bus.out),  32'(e.out));
            chk("busy", 32'(bus.busy), 32'(e.busy));
            chk("rise", 32'(bus.rise), 32'(e.rise));
            chk("fall", 32'(bus.fall), 32'(e.fall));
`ifdef JKB_TRANS_CNT_EN
            chk("trans_cnt", 32'(bus.trans_cnt), 32'(e.tc));
`endif
        end
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        model_reset();
        areset_n    = 1'b0;
        bus.en      = 1'b1;
        bus.j       = 4'hF;
        bus.k       = 4'h0;
        bus.jk_mode = 2'b00;
        bus.dwell   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out",  32'(bus.out),  32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_rise", 32'(bus.rise), 32'h0);
        chk("rst_fall", 32'(bus.fall), 32'h0);
        bus.j    = 4'h0;
        areset_n = 1'b1;

        // Basic set/clear on channel 0
        bus.j = 4'b0001; cycle();
        chk("set_out", 32'(bus.out), 32'h1);
        chk("set_rise", 32'(bus.rise), 32'h1);
        bus.j = 4'b0000; cycle();
        chk("rise_once", 32'(bus.rise), 32'h0);
        bus.k = 4'b0001; cycle();
        chk("clr_out", 32'(bus.out), 32'h0);
        chk("clr_fall", 32'(bus.fall), 32'h1);
        bus.k = 4'b0000; cycle();

        // Both-asserted policies with ch0 ON
        bus.j = 4'b0001; cycle();
        bus.k = 4'b0001;
        bus.jk_mode = 2'b00;
        for (int n = 0; n < 4; n++) begin
            cycle();
            chk("toggle", 32'(bus.out[0]), 32'(n % 2 == 1));
        end
        bus.jk_mode = 2'b01; cycle(); cycle();
        chk("hold", 32'(bus.out[0]), 32'h1);
        bus.jk_mode = 2'b10; cycle(); cycle();
        chk("setpri", 32'(bus.out[0]), 32'h1);
        bus.jk_mode = 2'b11; cycle(); cycle();
        chk("clrpri", 32'(bus.out[0]), 32'h0);
        bus.j = 4'b0000; bus.k = 4'b0000; cycle();

        // Dwell lockout, dwell changed to 0 mid-count
        bus.dwell = 4'd3; bus.j = 4'b0001; cycle();
        chk("dw_on", 32'(bus.out[0]), 32'h1);
        bus.j = 4'b0000; bus.k = 4'b0001; bus.dwell = 4'd0;
        for (int n = 0; n < 3; n++) begin
            chk("dw_busy", 32'(bus.busy[0]), 32'h1);
            cycle();
            chk("dw_locked", 32'(bus.out[0]), 32'h1);
        end
        chk("dw_free", 32'(bus.busy[0]), 32'h0);
        cycle();
        chk("dw_fall", 32'(bus.fall[0]), 32'h1);
        bus.k = 4'b0000; cycle();

        // Enable freeze during lockout
        bus.dwell = 4'd3; bus.j = 4'b0001; cycle();
        bus.j = 4'b0000; cycle();
        bus.en = 1'b0; bus.k = 4'b0001;
        for (int n = 0; n < 5; n++) begin
            cycle();
            chk("frz_out", 32'(bus.out[0]), 32'h1);
            chk("frz_busy", 32'(bus.busy[0]), 32'h1);
        end
        bus.en = 1'b1;
        cycle(); cycle(); cycle();
        chk("frz_fall", 32'(bus.fall[0]), 32'h1);
        bus.k = 4'b0000; bus.dwell = 4'd0;
        repeat (3) cycle();

        // Asynchronous reset between edges
        bus.dwell = 4'd2; bus.j = 4'hF; cycle();
        chk("ar_pre_out", 32'(bus.out), 32'hF);
        #3 areset_n = 1'b0;
        #1;
        chk("ar_out",  32'(bus.out),  32'h0);
        chk("ar_busy", 32'(bus.busy), 32'h0);
        chk("ar_rise", 32'(bus.rise), 32'h0);
        chk("ar_fall", 32'(bus.fall), 32'h0);
        sb.delete();
        model_reset();
        #1 areset_n = 1'b1;
        bus.dwell = 4'd0; cycle();
        chk("ar_free", 32'(bus.out), 32'hF);

        // All channels toggle together
        bus.k = 4'hF; bus.jk_mode = 2'b00;
        for (int n = 0; n < 5; n++) begin
            cycle();
            chk("all_tog", 32'(bus.out), (n % 2 == 0) ? 32'h0 : 32'hF);
        end
`ifdef JKB_TRANS_CNT_EN
        chk("tc_sat", 32'(bus.trans_cnt), 32'hF);
`endif

        // Random traffic
        for (int n = 0; n < 60; n++) begin
            bus.j       = CH'($urandom);
            bus.k       = CH'($urandom);
            bus.jk_mode = 2'($urandom_range(0, 3));
            bus.dwell   = DWELL_W'($urandom_range(0, 3));
            bus.en      = ($urandom_range(0, 7) != 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
